pq_io_adapter: RTL and testbench

PQ_IO_ADAPTER -- requirements
Module: pq_io_adapter

---
 rtl/pq_io_adapter.sv | 140 ++++++++++++++
 tb/tb_pq_io_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pq_io_adapter.sv
`default_nettype none
// ============================================================================
// Module      : pq_io_adapter
// Description : Valid/ready adapter around a shift-register priority queue,
//               with a 2-entry output buffer, small-key bypass and flush.
// Revision    : 1.0
// ============================================================================
module pq_io_adapter #(
   parameter int KW    = 4,
   parameter int VW    = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [KW+VW-1:0]             in_kv,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [KW+VW-1:0]             out_kv,
   input  logic                         out_ready,
   input  logic                         flush,
   output logic                         pq_push,
   output logic                         pq_pop,
   output logic [KW+VW-1:0]             pq_kvi,
   input  logic [KW+VW-1:0]             pq_kvo,
   input  logic                         pq_full,
   input  logic                         pq_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         key_err
);
   localparam int            c_W      = KW + VW;
   localparam int            c_CW     = $clog2(DEPTH + 1);
   localparam logic [KW-1:0] c_KEYINF = '1;
   localparam logic [0:0]    c_RUN    = 1'b0;
   localparam logic [0:0]    c_FLUSH  = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [1:0]      r_occ;
   logic [c_W-1:0]  r_obuf [2];
   logic [c_CW-1:0] r_count;
   logic            r_key_err;

   logic [KW-1:0]   w_in_key;
   logic [KW-1:0]   w_head_key;
   logic            w_out_fire;
   logic            w_space;
   logic            w_lt;
   logic            w_keyinf;
   logic            w_ready_run;
   logic            w_take;
   logic            w_push;
   logic            w_pop;
   logic            w_wr;
   logic            w_widx;
   logic [c_W-1:0]  w_wdata;

   assign w_in_key    = in_kv[c_W-1 -: KW];
   assign w_head_key  = pq_kvo[c_W-1 -: KW];
   assign w_out_fire  = out_valid && out_ready;
   assign w_space     = (r_occ < 2'd2) || w_out_fire;
   assign w_lt        = pq_empty || (w_in_key < w_head_key);
   assign w_keyinf    = (w_in_key == c_KEYINF);
   // KEYINF offers are always swallowed so a full queue cannot stall them.
   assign w_ready_run = w_keyinf || !pq_full || (w_space && w_lt);
   assign w_take      = (r_state == c_RUN) && in_valid && w_ready_run;
   // Write slot after any same-cycle shift: occ minus the departing entry.
   assign w_widx      = r_occ[1] || (r_occ[0] && !w_out_fire);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_RUN:   if (flush)    w_state_nxt = c_FLUSH;
         c_FLUSH: if (pq_empty) w_state_nxt = c_RUN;
         default:               w_state_nxt = c_RUN;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_wr     = 1'b0;
      w_wdata  = in_kv;
      if (r_state == c_RUN) begin
         in_ready = w_ready_run;
         if (w_take && !w_keyinf && w_space && w_lt) begin
            w_wr = 1'b1;
         end else begin
            w_pop   = w_space && !pq_empty;
            w_push  = w_take && !w_keyinf && !flush;
            w_wr    = w_pop;
            w_wdata = pq_kvo;
         end
         if (flush) w_wr = 1'b0;
      end else begin
         w_pop = !pq_empty;
      end
   end

   assign pq_push   = w_push && rst;
   assign pq_pop    = w_pop && rst;
   assign pq_kvi    = in_kv;
   assign out_valid = (r_occ != 2'd0) && (r_state == c_RUN);
   assign out_kv    = r_obuf[0];
   assign count     = r_count;
   assign key_err   = r_key_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_occ     <= 2'd0;
         r_count   <= '0;
         r_key_err <= 1'b0;
      end else begin
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         if (w_take && w_keyinf) r_key_err <= 1'b1;
         if ((r_state == c_RUN) && flush) begin
            r_occ <= 2'd0;
         end else begin
            r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_out_fire};
         end
      end
   end

   // Payload only; validity is carried by r_occ.
   always_ff @(posedge clk) begin
      if (w_out_fire) r_obuf[0] <= r_obuf[1];
      if (w_wr)       r_obuf[w_widx] <= w_wdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_pq_io_adapter.sv
`default_nettype none
// Testbench for pq_io_adapter with a behavioural shift-register priority queue.
module tb_pq_io_adapter;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, flush;
   logic [7:0] in_kv, out_kv, pq_kvi, pq_kvo;
   logic       pq_push, pq_pop, pq_full, pq_empty, key_err;
   logic [2:0] count;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   pq_io_adapter #(.KW(4), .VW(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_kv(in_kv), .in_ready(in_ready),
      .out_valid(out_valid), .out_kv(out_kv), .out_ready(out_ready),
      .flush(flush), .pq_push(pq_push), .pq_pop(pq_pop),
      .pq_kvi(pq_kvi), .pq_kvo(pq_kvo), .pq_full(pq_full),
      .pq_empty(pq_empty), .count(count), .key_err(key_err)
   );

   // Sorted queue model; equal keys keep arrival order.
   logic [7:0] mq [DEPTH];
   logic [7:0] nq [DEPTH];
   int mn, nn, p;

   assign pq_kvo   = (mn != 0) ? mq[0] : 8'hFF;
   assign pq_full  = (mn == DEPTH);
   assign pq_empty = (mn == 0);

   always_comb begin
      nq = mq;
      nn = mn;
      p  = 0;
      if (pq_pop && mn > 0) begin
         for (int i = 0; i < DEPTH-1; i++) nq[i] = nq[i+1];
         nq[DEPTH-1] = 8'hFF;
         nn = mn - 1;
      end
      if (pq_push && nn < DEPTH) begin
         p = nn;
         for (int i = DEPTH-1; i >= 0; i--)
            if (i < nn && nq[i][7:4] > pq_kvi[7:4]) p = i;
         for (int i = DEPTH-1; i > 0; i--)
            if (i > p) nq[i] = nq[i-1];
         nq[p] = pq_kvi;
         nn = nn + 1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mn <= 0;
         for (int i = 0; i < DEPTH; i++) mq[i] <= 8'hFF;
      end else begin
         mq <= nq;
         mn <= nn;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] kv);
      in_valid = 1'b1;
      in_kv    = kv;
      #2;
      check("push_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   logic [7:0] t2 [6] = '{8'h91, 8'h32, 8'h73, 8'h14, 8'h65, 8'h86};
   logic [7:0] e3 [6] = '{8'h91, 8'h32, 8'h14, 8'h65, 8'h73, 8'h86};
   logic [7:0] e4 [4] = '{8'hB0, 8'h22, 8'h41, 8'h61};

   initial begin
      rst = 1'b0; in_valid = 1'b1; in_kv = 8'h50; out_ready = 1'b0; flush = 1'b0;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_key_err",   32'(key_err),   32'd0);
      check("rst_push",      32'(pq_push),   32'd0);
      check("rst_pop",       32'(pq_pop),    32'd0);
      tick(); tick();
      rst = 1'b1; in_valid = 1'b0;
      tick();

      // Bypass into empty adapter
      in_valid = 1'b1; in_kv = 8'h5A;
      #2;
      check("byp_ready", 32'(in_ready), 32'd1);
      check("byp_push",  32'(pq_push),  32'd0);
      check("byp_pop",   32'(pq_pop),   32'd0);
      tick();
      in_valid = 1'b0;
      check("byp_valid", 32'(out_valid), 32'd1);
      check("byp_kv",    32'(out_kv),    32'h5A);
      check("byp_count", 32'(count),     32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("byp_drained", 32'(out_valid), 32'd0);

      // Fill obuf and queue with downstream stalled
      foreach (t2[i]) push(t2[i]);
      check("fill_count", 32'(count),   32'd4);
      check("fill_full",  32'(pq_full), 32'd1);
      check("fill_head",  32'(out_kv),  32'h91);
      in_valid = 1'b1; in_kv = 8'h05;
      #2;
      check("fill_blocked", 32'(in_ready), 32'd0);
      in_valid = 1'b0;

      // Drain
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #2;
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_kv",    32'(out_kv),    32'(e3[i]));
         tick();
      end
      check("drain_empty", 32'(out_valid), 32'd0);
      check("drain_count", 32'(count),     32'd0);
      out_ready = 1'b0;

      // Small key bypasses queued 4,6 while output drains
      push(8'hA0); push(8'hB0); push(8'h41); push(8'h61);
      out_ready = 1'b1; in_valid = 1'b1; in_kv = 8'h22;
      #2;
      check("byp2_ready", 32'(in_ready), 32'd1);
      check("byp2_push",  32'(pq_push),  32'd0);
      check("byp2_pop",   32'(pq_pop),   32'd0);
      check("byp2_head",  32'(out_kv),   32'hA0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         check("byp2_kv", 32'(out_kv), 32'(e4[i]));
         tick();
      end
      check("byp2_empty", 32'(out_valid), 32'd0);
      check("byp2_count", 32'(count),     32'd0);
      out_ready = 1'b0;

      // Flush with occ=2 and 3 queued
      push(8'h50); push(8'h60); push(8'h71); push(8'h72); push(8'h73);
      flush = 1'b1;
      #2;
      check("fl_count", 32'(count),  32'd3);
      check("fl_nopop", 32'(pq_pop), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b1; in_kv = 8'h10;
      #2;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready",  32'(in_ready),  32'd0);
      check("fl_push",      32'(pq_push),   32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("fl_pop", 32'(pq_pop), 32'd1);
         if (i == 1) flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      #2;
      check("fl_done_pop",   32'(pq_pop),   32'd0);
      check("fl_done_ready", 32'(in_ready), 32'd0);
      check("fl_done_count", 32'(count),    32'd0);
      tick();
      #2;
      check("fl_run_ready", 32'(in_ready),  32'd1);
      in_valid = 1'b0;
      check("fl_run_valid", 32'(out_valid), 32'd0);
      tick();

      // KEYINF offer
      push(8'h33);
      in_valid = 1'b1; in_kv = 8'hF5;
      #2;
      check("inf_ready", 32'(in_ready), 32'd1);
      check("inf_push",  32'(pq_push),  32'd0);
      tick();
      in_valid = 1'b0;
      check("inf_err",   32'(key_err),   32'd1);
      check("inf_count", 32'(count),     32'd0);
      check("inf_valid", 32'(out_valid), 32'd1);
      check("inf_kv",    32'(out_kv),    32'h33);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("inf_occ1",   32'(out_valid), 32'd0);
      check("inf_sticky", 32'(key_err),   32'd1);

      // Reset mid-transfer
      push(8'h77);
      check("mid_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_err",   32'(key_err),   32'd0);
      check("mid_rst_count", 32'(count),     32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
